// File: rtl/key_sched.sv
// Three-key schedule loader and phase-sequenced key presenter for a locked downstream FSM.
// Optional macro KEY_SCHED_LOCKOUT_EN makes the key schedule write-once per reset.
module key_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [9:0] load_data,
    output logic       load_ready,
    input  logic       start,
    input  logic       stop,
    output logic [9:0] keyout,
    output logic       key_valid,
    output logic [1:0] slot,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t     state_r;
    logic [1:0] idx_r;
    logic [2:0] phase_r;
    logic [9:0] key_r [0:2];
    logic       err_r;
    logic       reload_ok_s;
    logic       err_set_s;
    logic [1:0] slot_s;

`ifdef KEY_SCHED_LOCKOUT_EN
    logic armed_seen_r;

    assign reload_ok_s = ~armed_seen_r;

    // Remembers that a full schedule was armed since reset; set on the third accepted word.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            armed_seen_r <= 1'b0;
        end else if ((state_r == LOAD) && load_valid && !load_start && (idx_r == 2'd2)) begin
            armed_seen_r <= 1'b1;
        end else begin
            armed_seen_r <= armed_seen_r;
        end
    end
`else
    assign reload_ok_s = 1'b1;
`endif

    // Protocol violations: stray key words, start before a schedule is armed, locked-out reloads.
    always_comb begin
        err_set_s = 1'b0;
        if (load_valid && (state_r != LOAD)) begin
            err_set_s = 1'b1;
        end else if (start && (state_r != ARMED) && (state_r != RUN)) begin
            err_set_s = 1'b1;
        end else if (load_start && !reload_ok_s) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Main sequencer: loading, arming and the six-phase run window.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            idx_r    <= 2'd0;
            phase_r  <= 3'd0;
            key_r[0] <= 10'd0;
            key_r[1] <= 10'd0;
            key_r[2] <= 10'd0;
            err_r    <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
            case (state_r)
                IDLE: begin
                    if (load_start && reload_ok_s) begin
                        state_r <= LOAD;
                        idx_r   <= 2'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    // A restart takes priority over a word offered in the same cycle.
                    if (load_start && reload_ok_s) begin
                        idx_r <= 2'd0;
                    end else if (load_valid) begin
                        key_r[idx_r] <= load_data;
                        if (idx_r == 2'd2) begin
                            state_r <= ARMED;
                            idx_r   <= 2'd0;
                        end else begin
                            idx_r <= idx_r + 2'd1;
                        end
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ARMED: begin
                    if (load_start && reload_ok_s) begin
                        state_r <= LOAD;
                        idx_r   <= 2'd0;
                    end else if (start) begin
                        state_r <= RUN;
                        phase_r <= 3'd0;
                    end else begin
                        state_r <= ARMED;
                    end
                end
                RUN: begin
                    if (load_start && reload_ok_s) begin
                        state_r <= LOAD;
                        idx_r   <= 2'd0;
                        phase_r <= 3'd0;
                    end else if (stop) begin
                        state_r <= ARMED;
                        phase_r <= 3'd0;
                    end else if (start || (phase_r == 3'd5)) begin
                        phase_r <= 3'd0;
                    end else begin
                        phase_r <= phase_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= 2'd0;
                    phase_r <= 3'd0;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state/phase so the key settles before the consumer samples.
    always_comb begin
        load_ready = (state_r == LOAD);
        key_valid  = (state_r == RUN);
        keyout     = 10'd0;
        if (state_r == RUN) begin
            slot_s = phase_r[2:1];
            case (slot_s)
                2'd0:    keyout = key_r[0];
                2'd1:    keyout = key_r[1];
                2'd2:    keyout = key_r[2];
                default: keyout = 10'd0;
            endcase
        end else begin
            slot_s = 2'd0;
        end
    end

    assign slot = slot_s;
    assign err  = err_r;

endmodule
